ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It is the sending counterpart of the existing ps2_rx keyboard receiver.
- Sends one command byte to the keyboard, for example 8'hED (set LEDs) or 8'hFF (reset). Framing is start bit, 8 data bits LSB-first, odd parity, stop bit, then the device ACK.
- Shares the ps2c/ps2d pins with ps2_rx through open-drain enables.
- tx_idle drives ps2_rx.rx_en, so the receiver ignores the host's own frame.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles that ps2c is held low for request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: maximum clk cycles allowed between device falling edges once transmission starts (15 ms).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_ps2  in  1  one-cycle strobe; din is accepted only when tx_idle=1.
- din  in  8  byte to send.
- ps2c_in  in  1  sampled level of the PS/2 clock pin.
- ps2d_in  in  1  sampled level of the PS/2 data pin.
- ps2c_oe  out  1  1 = drive ps2c low; 0 = release the pin (pulled up).
- ps2d_oe  out  1  1 = drive ps2d low; 0 = release the pin.
- tx_idle  out  1  1 when no transfer is in progress.
- tx_done_tick  out  1  one-cycle pulse when the frame completes.
- ack_err  out  1  valid on tx_done_tick; 1 = device did not ACK (ps2d high at the 11th falling edge).
- timeout_tick  out  1  one-cycle pulse when a transfer is aborted by timeout.

Behaviour:
- Clock filtering:
  - ps2c_in passes through an 8-sample shift filter.
  - The filtered level goes to 1 on all-ones and to 0 on all-zeros; otherwise it holds.
  - fall_edge is a one-cycle pulse on a filtered 1->0 transition.
  - Same scheme as ps2_rx.
- Reset: synchronous; state=IDLE.
  - Output reset values: ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, ack_err=0, timeout_tick=0.
  - Counters and the shift register clear.
  - Reset asserted mid-transfer releases both lines on the next clk edge.
- Frame register: the 9-bit frame is {parity, din}, latched when wr_ps2 is accepted.
  - parity = ~^din (odd parity over the 8 data bits plus the parity bit).
- The data pin is driven with ps2d_oe = ~current_bit, i.e. pulled low for 0 and released for 1.
- FSM states:
  - IDLE: tx_idle=1.
    - On wr_ps2: latch the frame, clear the cycle counter, go to RTS.
    - wr_ps2 in any other state is ignored; the frame is not altered.
  - RTS: ps2c_oe=1, ps2d_oe=0; count clk cycles.
    - At count = INHIBIT_CYCLES-1, go to START.
  - START: ps2c_oe=0 (clock released), ps2d_oe=1 (start bit 0).
    - On fall_edge: go to DATA with n=8, presenting frame[0].
  - DATA: ps2d_oe = ~frame[0].
    - On fall_edge with n!=0: shift the frame right by one and decrement n.
    - On fall_edge with n=0 (parity is being presented): go to STOP with ps2d_oe=0.
    - d0 is presented at the 1st falling edge; parity is released at the 10th falling edge.
  - STOP: ps2d_oe=0.
    - On fall_edge (the 11th): capture ack = ~ps2d_in, go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0.
    - When filtered ps2c=1 and ps2d_in=1: tx_done_tick=1 for one cycle, ack_err=~ack, go to IDLE.
- Output timing:
  - ack_err holds its value until the next accepted wr_ps2, which clears it.
  - tx_idle drops in the cycle after wr_ps2 is accepted.
- Watchdog:
  - Runs in START, DATA, STOP and WAIT_IDLE.
  - Cleared on entry to START and on every fall_edge.
  - On reaching TIMEOUT_CYCLES-1: release both lines, timeout_tick=1 for one cycle, go to IDLE. No tx_done_tick is produced.
- Simultaneous events:
  - Timeout expiring in the same cycle as a fall_edge: the fall_edge wins and the watchdog clears.
  - wr_ps2 arriving in the same cycle as tx_done_tick: ignored, because tx_idle is still 0.
- Line policy:
  - ps2c_oe is never asserted outside RTS.
  - Both oe are never asserted outside the RTS-to-START boundary. RTS drives only ps2c and START only ps2d, so there is no overlap cycle.

Test Plan:
- Test parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=500. The bench device model produces falling edges every 40 cycles and checks ps2d on each rising edge.
- Reset then idle: after reset both oe=0 and tx_idle=1. A wr_ps2 while reset=1 is ignored.
- Send 8'hED: din=8'hED, wr_ps2 pulse ->
  - ps2c_oe=1 for exactly 20 cycles, then ps2d_oe=1.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - Model ACKs low -> tx_done_tick once, ack_err=0.
- Send 8'h00 with no ACK: data bits all 0, parity=1. Model leaves ps2d high at the 11th edge -> tx_done_tick with ack_err=1.
- Timeout: the model stops clocking after the 4th falling edge. After 500 cycles -> timeout_tick once, both oe=0, tx_idle=1, no tx_done_tick.
- Busy write: wr_ps2 with din=8'h55 during DATA of an 8'hFF transfer -> the device receives 8'hFF with parity 1, and no second frame follows.
- Reset mid-DATA: assert reset after the 5th falling edge -> both oe=0 on the next clk edge, tx_idle=1. A new wr_ps2 then sends a complete, correct frame.

Source files
------------

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// Lines are open-drain enables; tx_idle gates the companion receiver off during our own frame.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err,
    output logic       timeout_tick
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t        r_state, w_state_next;
    logic [7:0]    r_filt;
    logic          r_c_filt, w_c_filt_next, w_fall_edge;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_n, w_n_next;
    logic [8:0]    r_frame, w_frame_next;
    logic          r_ack_err, w_ack_err_next;
    logic          w_wdog_on;

    always_comb begin
        w_c_filt_next = r_c_filt;
        if (r_filt == 8'hFF)
            w_c_filt_next = 1'b1;
        else if (r_filt == 8'h00)
            w_c_filt_next = 1'b0;
    end

    assign w_fall_edge = r_c_filt & ~w_c_filt_next;
    assign w_wdog_on   = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_STOP)  || (r_state == S_WAIT_IDLE);
    assign ack_err     = r_ack_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_filt    <= 8'h00;
            r_c_filt  <= 1'b0;
            r_cnt     <= '0;
            r_n       <= 4'd0;
            r_frame   <= 9'd0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_filt    <= {ps2c_in, r_filt[7:1]};
            r_c_filt  <= w_c_filt_next;
            r_cnt     <= w_cnt_next;
            r_n       <= w_n_next;
            r_frame   <= w_frame_next;
            r_ack_err <= w_ack_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_n_next       = r_n;
        w_frame_next   = r_frame;
        w_ack_err_next = r_ack_err;
        ps2c_oe        = 1'b0;
        ps2d_oe        = 1'b0;
        tx_idle        = 1'b0;
        tx_done_tick   = 1'b0;
        timeout_tick   = 1'b0;

        // Watchdog: every device falling edge restarts the window
        if (w_wdog_on)
            w_cnt_next = w_fall_edge ? '0 : r_cnt + 1'b1;

        case (r_state)
            S_IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    w_frame_next   = {~^din, din};
                    w_cnt_next     = '0;
                    w_ack_err_next = 1'b0;
                    w_state_next   = S_RTS;
                end
            end
            S_RTS: begin
                ps2c_oe    = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == INH_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                ps2d_oe = 1'b1;
                if (w_fall_edge) begin
                    w_n_next     = 4'd8;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                ps2d_oe = ~r_frame[0];
                if (w_fall_edge) begin
                    if (r_n == 4'd0) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_frame_next = {1'b0, r_frame[8:1]};
                        w_n_next     = r_n - 4'd1;
                    end
                end
            end
            S_STOP: begin
                // Device pulls data low to ACK; a high line means no ACK
                if (w_fall_edge) begin
                    w_ack_err_next = ps2d_in;
                    w_state_next   = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (r_c_filt && ps2d_in) begin
                    tx_done_tick = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_wdog_on && !w_fall_edge && r_cnt == TMO_LAST) begin
            ps2d_oe      = 1'b0;
            tx_done_tick = 1'b0;
            timeout_tick = 1'b1;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
        end
    end
endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a behavioural keyboard clocks the frame and samples data on rising edges.
module tb_ps2_tx;
    localparam int INH = 20;
    localparam int TMO = 500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_tick;
    wire        ps2c_line = ~(ps2c_oe | dev_c_low);
    wire        ps2d_line = ~(ps2d_oe | dev_d_low);

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   tmo_cnt = 0;
    int   ovl_cnt = 0;
    logic done_ack_err = 1'b0;

    always #5 clk = ~clk;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
        .ps2c_in(ps2c_line), .ps2d_in(ps2d_line),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick), .ack_err(ack_err), .timeout_tick(timeout_tick)
    );

    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt     <= done_cnt + 1;
            done_ack_err <= ack_err;
        end
        if (timeout_tick)
            tmo_cnt <= tmo_cnt + 1;
        if (ps2c_oe && ps2d_oe)
            ovl_cnt <= ovl_cnt + 1;
    end

    task automatic host_write(input logic [7:0] d);
        @(negedge clk);
        din = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ps2d_oe === 1'b1 && ps2c_oe === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Keyboard: 20 cycles high, 20 low per bit; samples data one cycle after each rising edge.
    // bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_clock(input int nedges, input bit do_ack, output logic [10:0] bits);
        bits = '1;
        @(negedge clk);
        bits[0] = ps2d_line;
        for (int e = 1; e <= nedges; e++) begin
            for (int k = 0; k < 20; k++) begin
                if (e == 11 && k == 10)
                    dev_d_low = do_ack;
                @(negedge clk);
            end
            dev_c_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_c_low = 1'b0;
            @(negedge clk);
            if (e <= 10)
                bits[e] = ps2d_line;
        end
        repeat (5) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    task automatic test_reset();
        int viol;
        viol = 0;
        repeat (3) @(negedge clk);
        din = 8'hED;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ps2c_oe !== 1'b0 || tx_idle !== 1'b1) viol++;
        end
        n_cmp++; if (ps2c_oe !== 1'b0) begin n_bad++; $display("FAIL reset_ps2c_oe: got %b want 0", ps2c_oe); end
        n_cmp++; if (ps2d_oe !== 1'b0) begin n_bad++; $display("FAIL reset_ps2d_oe: got %b want 0", ps2d_oe); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle); end
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL reset_wr_ignored: got %0d busy cycles want 0", viol); end
        n_cmp++; if (done_cnt + tmo_cnt !== 0) begin n_bad++; $display("FAIL reset_ticks: got %0d want 0", done_cnt + tmo_cnt); end
    endtask

    task automatic test_send_ed();
        int cnt, d0;
        logic [10:0] bits;
        d0 = done_cnt;
        host_write(8'hED);
        cnt = 0;
        while (ps2c_oe === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++; if (cnt !== INH) begin n_bad++; $display("FAIL ed_rts_len: got %0d want %0d", cnt, INH); end
        n_cmp++; if (ps2d_oe !== 1'b1) begin n_bad++; $display("FAIL ed_start_oe: got %b want 1", ps2d_oe); end
        dev_clock(11, 1'b1, bits);
        repeat (20) @(negedge clk);
        n_cmp++; if (bits !== 11'b11_1110_1101_0) begin n_bad++; $display("FAIL ed_frame: got %b want %b", bits, 11'b11_1110_1101_0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ed_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (done_ack_err !== 1'b0) begin n_bad++; $display("FAIL ed_ack_err: got %b want 0", done_ack_err); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL ed_idle: got %b want 1", tx_idle); end
    endtask

    task automatic test_no_ack();
        int d0;
        bit ok;
        logic [10:0] bits;
        d0 = done_cnt;
        host_write(8'h00);
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL noack_start: got %b want 1", ok); end
        dev_clock(11, 1'b0, bits);
        repeat (20) @(negedge clk);
        n_cmp++; if (bits !== 11'b11_0000_0000_0) begin n_bad++; $display("FAIL noack_frame: got %b want %b", bits, 11'b11_0000_0000_0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL noack_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (done_ack_err !== 1'b1) begin n_bad++; $display("FAIL noack_ack_err: got %b want 1", done_ack_err); end
        repeat (50) @(negedge clk);
        n_cmp++; if (ack_err !== 1'b1) begin n_bad++; $display("FAIL noack_hold: got %b want 1", ack_err); end
    endtask

    task automatic test_timeout();
        int d0, t0;
        bit ok;
        logic [10:0] bits;
        d0 = done_cnt;
        t0 = tmo_cnt;
        host_write(8'h3C);
        n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL tmo_ack_clear: got %b want 0", ack_err); end
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tmo_start: got %b want 1", ok); end
        dev_clock(4, 1'b1, bits);
        n_cmp++; if (bits[4:0] !== 5'b11000) begin n_bad++; $display("FAIL tmo_partial: got %b want 11000", bits[4:0]); end
        repeat (400) @(negedge clk);
        n_cmp++; if (tmo_cnt - t0 !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d want 0", tmo_cnt - t0); end
        for (int i = 0; i < 300 && tmo_cnt == t0; i++) @(negedge clk);
        @(negedge clk);
        n_cmp++; if (tmo_cnt - t0 !== 1) begin n_bad++; $display("FAIL tmo_tick: got %0d want 1", tmo_cnt - t0); end
        n_cmp++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin n_bad++; $display("FAIL tmo_release: got %b want 00", {ps2c_oe, ps2d_oe}); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL tmo_idle: got %b want 1", tx_idle); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL tmo_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int d0, viol;
        bit ok;
        logic [10:0] bits;
        d0 = done_cnt;
        viol = 0;
        host_write(8'hFF);
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_start: got %b want 1", ok); end
        fork
            dev_clock(11, 1'b1, bits);
            begin
                repeat (150) @(negedge clk);
                din = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        n_cmp++; if (bits !== 11'b11_1111_1111_0) begin n_bad++; $display("FAIL busy_frame: got %b want %b", bits, 11'b11_1111_1111_0); end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ps2c_oe !== 1'b0 || tx_idle !== 1'b1) viol++;
        end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL busy_second_frame: got %0d busy cycles want 0", viol); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        logic [10:0] bits;
        host_write(8'h0F);
        wait_start(ok);
        dev_clock(5, 1'b1, bits);
        n_cmp++; if (ps2d_oe !== 1'b1) begin n_bad++; $display("FAIL rmid_presenting_d4: got %b want 1", ps2d_oe); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin n_bad++; $display("FAIL rmid_release: got %b want 00", {ps2c_oe, ps2d_oe}); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL rmid_idle: got %b want 1", tx_idle); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        host_write(8'hA5);
        wait_start(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %b want 1", ok); end
        dev_clock(11, 1'b1, bits);
        repeat (20) @(negedge clk);
        n_cmp++; if (bits !== 11'b11_1010_0101_0) begin n_bad++; $display("FAIL rmid_frame: got %b want %b", bits, 11'b11_1010_0101_0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rmid_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (done_ack_err !== 1'b0) begin n_bad++; $display("FAIL rmid_ack_err: got %b want 0", done_ack_err); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_no_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (ovl_cnt !== 0) begin n_bad++; $display("FAIL line_overlap: got %0d cycles want 0", ovl_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
